// File: rtl/axrm_pkg.sv
// Shared types and helpers for the approximate-multiplier error monitor.
package axrm_pkg;

   localparam int OP_W   = 8;
   localparam int PROD_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Unsigned magnitude of the difference between two products.
   function automatic logic [PROD_W-1:0] abs_diff16(input logic [PROD_W-1:0] x,
                                                    input logic [PROD_W-1:0] y);
      return (x >= y) ? (x - y) : (y - x);
   endfunction

endpackage

// File: rtl/axrm_err_accum.sv
// Error-metric accumulators: sample/error counters, saturating ED sum and
// first-occurrence maximum ED with the operands that produced it.
module axrm_err_accum
   import axrm_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int SUM_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              valid_i,
   input  logic [PROD_W-1:0] ed_i,
   input  logic [OP_W-1:0]   a_i,
   input  logic [OP_W-1:0]   b_i,
   output logic [CNT_W-1:0]  sample_count_o,
   output logic [CNT_W-1:0]  err_count_o,
   output logic [SUM_W-1:0]  ed_sum_o,
   output logic [PROD_W-1:0] ed_max_o,
   output logic [OP_W-1:0]   ed_max_a_o,
   output logic [OP_W-1:0]   ed_max_b_o
);

   // One extra bit over the wider operand so the carry out of the add is visible.
   localparam int EXT_W = ((SUM_W > PROD_W) ? SUM_W : PROD_W) + 1;
   localparam logic [EXT_W-1:0] SUM_MAX = (EXT_W'(1) << SUM_W) - EXT_W'(1);

   logic [CNT_W-1:0]  sample_count_q, err_count_q;
   logic [SUM_W-1:0]  ed_sum_q, ed_sum_d;
   logic [PROD_W-1:0] ed_max_q;
   logic [OP_W-1:0]   ed_max_a_q, ed_max_b_q;
   logic [EXT_W-1:0]  sum_ext;

   // Saturating next value of the ED sum.
   always_comb begin
      // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
      sum_ext  = EXT_W'(ed_sum_q) + EXT_W'(ed_i);
      ed_sum_d = ed_sum_q;
      if (sum_ext > SUM_MAX) ed_sum_d = {SUM_W{1'b1}};
      else                   ed_sum_d = sum_ext[SUM_W-1:0];
   end

   // Retire one S2 sample per cycle; clear wins over a retiring sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_count_q <= '0;
         err_count_q    <= '0;
         ed_sum_q       <= '0;
         ed_max_q       <= '0;
         ed_max_a_q     <= '0;
         ed_max_b_q     <= '0;
      end else if (clear_i) begin
         sample_count_q <= '0;
         err_count_q    <= '0;
         ed_sum_q       <= '0;
         ed_max_q       <= '0;
         ed_max_a_q     <= '0;
         ed_max_b_q     <= '0;
      end else if (valid_i) begin
         sample_count_q <= sample_count_q + CNT_W'(1);
         err_count_q    <= err_count_q + CNT_W'(ed_i != '0);
         ed_sum_q       <= ed_sum_d;
         // Strictly greater: ties keep the first sample, ED=0 never updates.
         if (ed_i > ed_max_q) begin
            ed_max_q   <= ed_i;
            ed_max_a_q <= a_i;
            ed_max_b_q <= b_i;
         end
      end
   end

   assign sample_count_o = sample_count_q;
   assign err_count_o    = err_count_q;
   assign ed_sum_o       = ed_sum_q;
   assign ed_max_o       = ed_max_q;
   assign ed_max_a_o     = ed_max_a_q;
   assign ed_max_b_o     = ed_max_b_q;

endmodule

// File: rtl/axrm_error_monitor.sv
// Error monitor top: run-control FSM, accept counter, S1 exact-product
// register, S2 error-distance register, and the metric accumulators.
module axrm_error_monitor
   import axrm_pkg::*;
#(
   parameter int NUM_SAMPLES = 256,
   parameter int CNT_W       = 16,
   parameter int SUM_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_a,
   input  logic [OP_W-1:0]   in_b,
   input  logic [PROD_W-1:0] in_approx,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  sample_count,
   output logic [CNT_W-1:0]  err_count,
   output logic [SUM_W-1:0]  ed_sum,
   output logic [PROD_W-1:0] ed_max,
   output logic [OP_W-1:0]   ed_max_a,
   output logic [OP_W-1:0]   ed_max_b
);

   if (NUM_SAMPLES < 1 || NUM_SAMPLES > (2 ** CNT_W) - 1) begin : g_bad_num_samples
      $error("axrm_error_monitor: NUM_SAMPLES out of range 1 .. 2^CNT_W-1");
   end

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

   state_e            state_q;
   logic [CNT_W-1:0]  acc_cnt_q;
   logic              in_ready_q, busy_q, done_q;
   logic              accept, start_run;

   logic              s1_valid_q;
   logic [OP_W-1:0]   s1_a_q, s1_b_q;
   logic [PROD_W-1:0] s1_approx_q, s1_exact_q;

   logic              s2_valid_q;
   logic [PROD_W-1:0] s2_ed_q;
   logic [OP_W-1:0]   s2_a_q, s2_b_q;

   assign accept    = in_valid && in_ready_q;
   assign start_run = start && (state_q == IDLE || state_q == DONE);

   // Run control with registered in_ready/busy/done.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q    <= IDLE;
         acc_cnt_q  <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q    <= RUN;
                  acc_cnt_q  <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
               end
            end
            RUN: begin
               if (accept) begin
                  acc_cnt_q <= acc_cnt_q + CNT_W'(1);
                  if (acc_cnt_q == LAST_IDX) begin
                     state_q    <= FLUSH;
                     in_ready_q <= 1'b0;
                  end
               end
            end
            FLUSH: begin
               // Once S1 is empty, S2's last sample retires on this same edge,
               // so the metrics are final when done rises.
               if (!s1_valid_q) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // S1: capture operands, approximate product and the exact product.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: data registers are reset too; the pipeline is tiny and reset values keep outputs defined.
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_approx_q <= '0;
         s1_exact_q  <= '0;
      end else begin
         s1_valid_q <= accept && !start_run;
         if (accept) begin
            s1_a_q      <= in_a;
            s1_b_q      <= in_b;
            s1_approx_q <= in_approx;
            s1_exact_q  <= PROD_W'(in_a) * PROD_W'(in_b);
         end
      end
   end

   // S2: error distance between exact and approximate products.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         s2_ed_q    <= '0;
         s2_a_q     <= '0;
         s2_b_q     <= '0;
      end else begin
         s2_valid_q <= s1_valid_q && !start_run;
         if (s1_valid_q) begin
            s2_ed_q <= abs_diff16(s1_exact_q, s1_approx_q);
            s2_a_q  <= s1_a_q;
            s2_b_q  <= s1_b_q;
         end
      end
   end

   axrm_err_accum #(
      .CNT_W (CNT_W),
      .SUM_W (SUM_W)
   ) u_accum (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear_i        (start_run),
      .valid_i        (s2_valid_q),
      .ed_i           (s2_ed_q),
      .a_i            (s2_a_q),
      .b_i            (s2_b_q),
      .sample_count_o (sample_count),
      .err_count_o    (err_count),
      .ed_sum_o       (ed_sum),
      .ed_max_o       (ed_max),
      .ed_max_a_o     (ed_max_a),
      .ed_max_b_o     (ed_max_b)
   );

   assign in_ready = in_ready_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_axrm_error_monitor.sv
// Bench for axrm_error_monitor: three instances (4 samples, 1 sample,
// 2 samples with an 8-bit sum) share the data inputs; each has its own start.
module tb_axrm_error_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [2:0]  start_v;
   logic        in_valid;
   logic [7:0]  in_a, in_b;
   logic [15:0] in_approx;

   logic [2:0]  busy_w, done_w, ready_w;
   logic [15:0] scnt_w [3];
   logic [15:0] ecnt_w [3];
   logic [15:0] emax_w [3];
   logic [7:0]  ma_w   [3];
   logic [7:0]  mb_w   [3];
   logic [31:0] sum0, sum1;
   logic [7:0]  sum2;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic        v;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] ap;
   } stim_t;

   typedef struct {
      logic        busy, done, ready;
      logic [15:0] scnt, ecnt, emax;
      logic [7:0]  ma, mb;
      logic [31:0] sum;
   } obs_t;

   stim_t stim_q[$];

   axrm_error_monitor #(.NUM_SAMPLES(4)) u_n4 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(in_valid), .in_ready(ready_w[0]),
      .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .busy(busy_w[0]), .done(done_w[0]),
      .sample_count(scnt_w[0]), .err_count(ecnt_w[0]), .ed_sum(sum0), .ed_max(emax_w[0]),
      .ed_max_a(ma_w[0]), .ed_max_b(mb_w[0]));

   axrm_error_monitor #(.NUM_SAMPLES(1)) u_n1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(in_valid), .in_ready(ready_w[1]),
      .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .busy(busy_w[1]), .done(done_w[1]),
      .sample_count(scnt_w[1]), .err_count(ecnt_w[1]), .ed_sum(sum1), .ed_max(emax_w[1]),
      .ed_max_a(ma_w[1]), .ed_max_b(mb_w[1]));

   axrm_error_monitor #(.NUM_SAMPLES(2), .SUM_W(8)) u_s8 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_valid(in_valid), .in_ready(ready_w[2]),
      .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .busy(busy_w[2]), .done(done_w[2]),
      .sample_count(scnt_w[2]), .err_count(ecnt_w[2]), .ed_sum(sum2), .ed_max(emax_w[2]),
      .ed_max_a(ma_w[2]), .ed_max_b(mb_w[2]));

   function automatic obs_t observe(input int idx);
      obs_t o;
      o.busy  = busy_w[idx];
      o.done  = done_w[idx];
      o.ready = ready_w[idx];
      o.scnt  = scnt_w[idx];
      o.ecnt  = ecnt_w[idx];
      o.emax  = emax_w[idx];
      o.ma    = ma_w[idx];
      o.mb    = mb_w[idx];
      o.sum   = (idx == 0) ? sum0 : (idx == 1) ? sum1 : {24'd0, sum2};
      return o;
   endfunction

   task automatic add_stim(input logic v, input int a, input int b, input int ap);
      stim_t s;
      s.v  = v;
      s.a  = 8'(a);
      s.b  = 8'(b);
      s.ap = 16'(ap);
      stim_q.push_back(s);
   endtask

   // Random stimulus with enough valid beats for n acceptances plus a few extras.
   task automatic gen_random(input int n);
      int vcount = 0;
      stim_q.delete();
      while (vcount < n + 2) begin
         stim_t s;
         int    ex, mode;
         s.v  = ($urandom_range(0, 3) != 0);
         s.a  = 8'($urandom_range(0, 255));
         s.b  = 8'($urandom_range(0, 255));
         ex   = int'(s.a) * int'(s.b);
         mode = $urandom_range(0, 2);
         if (mode == 0)      s.ap = 16'(ex);
         else if (mode == 1) s.ap = 16'((ex + $urandom_range(0, 40) + 65536 - 20) % 65536);
         else                s.ap = 16'($urandom_range(0, 65535));
         stim_q.push_back(s);
         if (s.v) vcount++;
      end
   endtask

   // Drive one run on instance idx from stim_q, then check timing and the
   // final metrics against a reference computed from the accepted samples.
   task automatic do_run(input int idx, input int n, input int sw,
                         input bit hold_extra, input bit start_in_flush, input string tag);
      stim_t  acc_q[$];
      obs_t   o;
      int     k = 0;
      int     acc = 0;
      longint e_sum = 0;
      int     e_err = 0, e_max = 0, e_ma = 0, e_mb = 0;

      @(negedge clk);
      start_v[idx] = 1'b1;
      in_valid     = 1'b0;
      @(negedge clk);
      start_v[idx] = 1'b0;
      o = observe(idx);
      total++;
      if (o.busy !== 1'b1 || o.done !== 1'b0 || o.scnt !== 16'd0)
         $display("FAIL %s_start: busy=%0b done=%0b count=%0d, required busy=1 done=0 count=0",
                  tag, o.busy, o.done, o.scnt);
      else passed++;

      while (acc < n && k < stim_q.size()) begin
         in_valid  = stim_q[k].v;
         in_a      = stim_q[k].a;
         in_b      = stim_q[k].b;
         in_approx = stim_q[k].ap;
         o = observe(idx);
         total++;
         if (o.ready !== 1'b1 || o.busy !== 1'b1)
            $display("FAIL %s_run_ready: ready=%0b busy=%0b at beat %0d, required 1 1", tag, o.ready, o.busy, k);
         else passed++;
         @(negedge clk);
         if (stim_q[k].v) begin
            acc_q.push_back(stim_q[k]);
            acc++;
         end
         k++;
      end
      total++;
      if (acc != n) $display("FAIL %s_stim: accepted %0d, required %0d", tag, acc, n);
      else passed++;

      // First flush cycle: optionally hold a further valid sample and pulse start.
      in_valid  = hold_extra;
      in_a      = 8'h55;
      in_b      = 8'h66;
      in_approx = 16'h0000;
      if (start_in_flush) start_v[idx] = 1'b1;
      o = observe(idx);
      total++;
      if (o.ready !== 1'b0 || o.busy !== 1'b1 || o.done !== 1'b0)
         $display("FAIL %s_flush1: ready=%0b busy=%0b done=%0b, required 0 1 0", tag, o.ready, o.busy, o.done);
      else passed++;
      @(negedge clk);
      start_v[idx] = 1'b0;
      o = observe(idx);
      total++;
      if (o.ready !== 1'b0 || o.busy !== 1'b1 || o.done !== 1'b0)
         $display("FAIL %s_flush2: ready=%0b busy=%0b done=%0b, required 0 1 0", tag, o.ready, o.busy, o.done);
      else passed++;
      @(negedge clk);

      foreach (acc_q[i]) begin
         int ex, ap, ed;
         ex = int'(acc_q[i].a) * int'(acc_q[i].b);
         ap = int'(acc_q[i].ap);
         ed = (ex > ap) ? ex - ap : ap - ex;
         if (ed != 0) e_err++;
         e_sum += ed;
         if (ed > e_max) begin
            e_max = ed;
            e_ma  = int'(acc_q[i].a);
            e_mb  = int'(acc_q[i].b);
         end
      end
      if (e_sum > (64'd1 << sw) - 1) e_sum = (64'd1 << sw) - 1;

      o = observe(idx);
      total++;
      if (o.done !== 1'b1 || o.busy !== 1'b0 || o.ready !== 1'b0)
         $display("FAIL %s_done: done=%0b busy=%0b ready=%0b, required 1 0 0", tag, o.done, o.busy, o.ready);
      else passed++;
      total++;
      if (o.scnt !== 16'(n)) $display("FAIL %s_sample_count: got %0d required %0d", tag, o.scnt, n);
      else passed++;
      total++;
      if (o.ecnt !== 16'(e_err)) $display("FAIL %s_err_count: got %0d required %0d", tag, o.ecnt, e_err);
      else passed++;
      total++;
      if (o.sum !== 32'(e_sum)) $display("FAIL %s_ed_sum: got %0d required %0d", tag, o.sum, e_sum);
      else passed++;
      total++;
      if (o.emax !== 16'(e_max) || o.ma !== 8'(e_ma) || o.mb !== 8'(e_mb))
         $display("FAIL %s_ed_max: got %0d (%0d,%0d) required %0d (%0d,%0d)",
                  tag, o.emax, o.ma, o.mb, e_max, e_ma, e_mb);
      else passed++;

      if (hold_extra) begin
         repeat (2) @(negedge clk);
         o = observe(idx);
         total++;
         if (o.scnt !== 16'(n) || o.done !== 1'b1)
            $display("FAIL %s_held_sample: count=%0d done=%0b, required %0d 1", tag, o.scnt, o.done, n);
         else passed++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      obs_t o;
      rst_n     = 1'b0;
      start_v   = '0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_approx = '0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         o = observe(i);
         total++;
         if (o.busy !== 1'b0 || o.done !== 1'b0 || o.ready !== 1'b0 || o.scnt !== 16'd0 ||
             o.ecnt !== 16'd0 || o.sum !== 32'd0 || o.emax !== 16'd0 || o.ma !== 8'd0 || o.mb !== 8'd0)
            $display("FAIL reset_%0d: busy=%0b done=%0b ready=%0b count=%0d sum=%0d, required all 0",
                     i, o.busy, o.done, o.ready, o.scnt, o.sum);
         else passed++;
      end
      rst_n = 1'b1;
   endtask

   task automatic test_exact();
      stim_q.delete();
      add_stim(1, 3, 5, 15);
      add_stim(1, 255, 255, 65025);
      add_stim(1, 10, 10, 100);
      add_stim(1, 0, 200, 0);
      do_run(0, 4, 32, 0, 0, "exact");
   endtask

   task automatic test_tie();
      stim_q.delete();
      add_stim(1, 12, 12, 140);
      add_stim(1, 200, 100, 19990);
      add_stim(1, 7, 9, 53);
      add_stim(1, 0, 0, 0);
      do_run(0, 4, 32, 0, 0, "tie");
   endtask

   task automatic test_signs();
      stim_q.delete();
      add_stim(1, 2, 3, 9);
      add_stim(1, 4, 4, 14);
      add_stim(1, 1, 1, 1);
      add_stim(1, 0, 0, 0);
      do_run(0, 4, 32, 0, 0, "signs");
   endtask

   task automatic test_backpressure();
      stim_q.delete();
      add_stim(1, 9, 9, 80);
      add_stim(0, 1, 2, 3);
      add_stim(1, 50, 60, 3000);
      add_stim(1, 17, 3, 40);
      add_stim(0, 4, 5, 6);
      add_stim(1, 100, 2, 150);
      do_run(0, 4, 32, 1, 0, "backpressure");
   endtask

   task automatic test_single_flush_start();
      stim_q.delete();
      add_stim(0, 1, 1, 1);
      add_stim(1, 20, 30, 590);
      do_run(1, 1, 32, 0, 1, "single");
   endtask

   task automatic test_saturate();
      stim_q.delete();
      add_stim(1, 10, 20, 0);
      add_stim(1, 10, 10, 0);
      do_run(2, 2, 8, 0, 0, "saturate");
   endtask

   task automatic test_reset_mid_run();
      obs_t o;
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      in_valid   = 1'b1;
      in_a       = 8'd6;
      in_b       = 8'd7;
      in_approx  = 16'd40;
      @(negedge clk);
      in_a       = 8'd11;
      in_b       = 8'd13;
      in_approx  = 16'd150;
      @(negedge clk);
      in_valid   = 1'b0;
      repeat (2) @(negedge clk);
      o = observe(0);
      total++;
      if (o.scnt !== 16'd2 || o.busy !== 1'b1)
         $display("FAIL midrun_pre: count=%0d busy=%0b, required 2 1", o.scnt, o.busy);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      o = observe(0);
      total++;
      if (o.busy !== 1'b0 || o.done !== 1'b0 || o.ready !== 1'b0 || o.scnt !== 16'd0 ||
          o.ecnt !== 16'd0 || o.sum !== 32'd0 || o.emax !== 16'd0)
         $display("FAIL midrun_reset: busy=%0b ready=%0b count=%0d err=%0d sum=%0d, required all 0",
                  o.busy, o.ready, o.scnt, o.ecnt, o.sum);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      gen_random(4);
      do_run(0, 4, 32, 0, 0, "after_reset");
   endtask

   task automatic test_random();
      for (int r = 0; r < 9; r++) begin
         int idx;
         idx = r % 3;
         gen_random((idx == 0) ? 4 : (idx == 1) ? 1 : 2);
         do_run(idx, (idx == 0) ? 4 : (idx == 1) ? 1 : 2, (idx == 2) ? 8 : 32,
                r[0], r[1], "random");
      end
   endtask

   initial begin
      test_reset();
      test_exact();
      test_tie();
      test_signs();
      test_backpressure();
      test_single_flush_start();
      test_saturate();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
